// File: rtl/cat_mac_pkg.sv
// cat_mac_pkg: AXI-Lite response codes and guard FSM state encodings.
package cat_mac_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {WR_IDLE, WR_FWD, WR_WAIT_B, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FWD, RD_WAIT_R, RD_RESP} rd_state_t;

endpackage

// File: rtl/axil_guard_timer.sv
// axil_guard_timer: per-channel watchdog counter that flags the last allowed cycle.
module axil_guard_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;

    assign expire = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sda_axil_guard.sv
// sda_axil_guard: AXI-Lite guard that forwards legal accesses, answers out-of-range ones
// with DECERR and turns stalled downstream accesses into SLVERR.
module sda_axil_guard
    import cat_mac_pkg::*;
#(
    parameter int                ADDR_W         = 12,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT     = 12'h100,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [31:0]       ERR_DATA       = 32'hBAD0_0BAD
) (
    input  logic              clk_main_a0,
    input  logic              rst_main,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_awready,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [15:0]       timeout_cnt
);

    wr_state_t         wr_state_q, wr_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic              aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    logic              wr_late_q, wr_late_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              aw_fire, w_fire, wr_expire, wr_timeout;

    rd_state_t         rd_state_q, rd_state_d;
    logic              rd_late_q, rd_late_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_expire, rd_timeout;

    logic [15:0]       timeout_cnt_q, timeout_cnt_d;
    logic [16:0]       cnt_sum;

    axil_guard_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timer (
        .clk    (clk_main_a0),
        .rst    (rst_main),
        .clr    (wr_state_q == WR_IDLE),
        .en     (wr_state_q == WR_FWD || wr_state_q == WR_WAIT_B),
        .expire (wr_expire)
    );

    axil_guard_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timer (
        .clk    (clk_main_a0),
        .rst    (rst_main),
        .clr    (rd_state_q == RD_IDLE),
        .en     (rd_state_q == RD_FWD || rd_state_q == RD_WAIT_R),
        .expire (rd_expire)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_pend_d  = aw_pend_q;
        w_pend_d   = w_pend_q;
        wr_late_d  = wr_late_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_timeout = 1'b0;
        aw_fire    = wr_state_q == WR_IDLE && !aw_held_q && s_awvalid;
        w_fire     = wr_state_q == WR_IDLE && !w_held_q && s_wvalid;
        if (aw_fire) awaddr_d = s_awaddr;
        if (w_fire) begin
            wdata_d = s_wdata;
            wstrb_d = s_wstrb;
        end
        if (wr_late_q && m_bvalid) wr_late_d = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                aw_held_d = aw_held_q || aw_fire;
                w_held_d  = w_held_q || w_fire;
                if (aw_held_d && w_held_d) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    if (awaddr_d >= ADDR_LIMIT) begin
                        bresp_d    = RESP_DECERR;
                        wr_state_d = WR_RESP;
                    end else begin
                        aw_pend_d  = 1'b1;
                        w_pend_d   = 1'b1;
                        wr_state_d = WR_FWD;
                    end
                end
            end
            WR_FWD: begin
                if (m_awready) aw_pend_d = 1'b0;
                if (m_wready) w_pend_d = 1'b0;
                if (wr_expire) begin
                    aw_pend_d  = 1'b0;
                    w_pend_d   = 1'b0;
                    wr_timeout = 1'b1;
                end else if (!aw_pend_d && !w_pend_d) begin
                    wr_state_d = WR_WAIT_B;
                end
            end
            WR_WAIT_B: begin
                if (m_bvalid && !wr_late_q) begin
                    bresp_d    = m_bresp;
                    wr_state_d = WR_RESP;
                end else if (wr_expire) begin
                    wr_timeout = 1'b1;
                end
            end
            WR_RESP: wr_state_d = s_bready ? WR_IDLE : WR_RESP;
            default: wr_state_d = WR_IDLE;
        endcase
        if (wr_timeout) begin
            bresp_d    = RESP_SLVERR;
            wr_late_d  = 1'b1;
            wr_state_d = WR_RESP;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_late_d  = rd_late_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_timeout = 1'b0;
        if (rd_late_q && m_rvalid) rd_late_d = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (s_arvalid) begin
                    araddr_d = s_araddr;
                    if (s_araddr >= ADDR_LIMIT) begin
                        rresp_d    = RESP_DECERR;
                        rdata_d    = ERR_DATA;
                        rd_state_d = RD_RESP;
                    end else begin
                        rd_state_d = RD_FWD;
                    end
                end
            end
            RD_FWD: begin
                if (rd_expire) rd_timeout = 1'b1;
                else if (m_arready) rd_state_d = RD_WAIT_R;
            end
            RD_WAIT_R: begin
                if (m_rvalid && !rd_late_q) begin
                    rresp_d    = m_rresp;
                    rdata_d    = m_rdata;
                    rd_state_d = RD_RESP;
                end else if (rd_expire) begin
                    rd_timeout = 1'b1;
                end
            end
            RD_RESP: rd_state_d = s_rready ? RD_IDLE : RD_RESP;
            default: rd_state_d = RD_IDLE;
        endcase
        if (rd_timeout) begin
            rresp_d    = RESP_SLVERR;
            rdata_d    = ERR_DATA;
            rd_late_d  = 1'b1;
            rd_state_d = RD_RESP;
        end
    end

    always_comb begin
        cnt_sum       = {1'b0, timeout_cnt_q} + 17'(wr_timeout) + 17'(rd_timeout);
        timeout_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main) begin
            wr_state_q    <= WR_IDLE;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            aw_pend_q     <= 1'b0;
            w_pend_q      <= 1'b0;
            wr_late_q     <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bresp_q       <= '0;
            rd_state_q    <= RD_IDLE;
            rd_late_q     <= 1'b0;
            araddr_q      <= '0;
            rdata_q       <= '0;
            rresp_q       <= '0;
            timeout_cnt_q <= '0;
        end else begin
            wr_state_q    <= wr_state_d;
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            aw_pend_q     <= aw_pend_d;
            w_pend_q      <= w_pend_d;
            wr_late_q     <= wr_late_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bresp_q       <= bresp_d;
            rd_state_q    <= rd_state_d;
            rd_late_q     <= rd_late_d;
            araddr_q      <= araddr_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    // Outputs are forced low during reset so nothing leaks before the first reset edge.
    assign s_awready   = !rst_main && wr_state_q == WR_IDLE && !aw_held_q;
    assign s_wready    = !rst_main && wr_state_q == WR_IDLE && !w_held_q;
    assign s_bvalid    = !rst_main && wr_state_q == WR_RESP;
    assign s_bresp     = rst_main ? '0 : bresp_q;
    assign m_awvalid   = !rst_main && wr_state_q == WR_FWD && aw_pend_q;
    assign m_wvalid    = !rst_main && wr_state_q == WR_FWD && w_pend_q;
    assign m_awaddr    = rst_main ? '0 : awaddr_q;
    assign m_wdata     = rst_main ? '0 : wdata_q;
    assign m_wstrb     = rst_main ? '0 : wstrb_q;
    assign m_bready    = !rst_main && (wr_state_q == WR_WAIT_B || wr_late_q);
    assign s_arready   = !rst_main && rd_state_q == RD_IDLE;
    assign s_rvalid    = !rst_main && rd_state_q == RD_RESP;
    assign s_rresp     = rst_main ? '0 : rresp_q;
    assign s_rdata     = rst_main ? '0 : rdata_q;
    assign m_arvalid   = !rst_main && rd_state_q == RD_FWD;
    assign m_araddr    = rst_main ? '0 : araddr_q;
    assign m_rready    = !rst_main && (rd_state_q == RD_WAIT_R || rd_late_q);
    assign timeout_cnt = rst_main ? '0 : timeout_cnt_q;

endmodule

// File: tb/tb_sda_axil_guard.sv
// tb_sda_axil_guard: directed checks of forwarding, DECERR, timeout and reset behaviour.
module tb_sda_axil_guard;

    logic        clk = 1'b0;
    logic        rst_main;
    logic [11:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_wdata, s_rdata, m_wdata, m_rdata;
    logic [3:0]  s_wstrb, m_wstrb;
    logic [1:0]  s_bresp, s_rresp, m_bresp, m_rresp;
    logic        m_awvalid, m_wvalid, m_awready, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [15:0] timeout_cnt;
    int          tests = 0;
    int          fails = 0;
    int          n;

    sda_axil_guard #(.TIMEOUT_CYCLES(8)) dut (
        .clk_main_a0(clk), .rst_main(rst_main),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_awready(m_awready), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .timeout_cnt(timeout_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    initial begin
        rst_main = 1'b1;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
        tick(); tick();
        chk("rst_awready", s_awready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bready", m_bready, 0);
        chk("rst_tcnt", timeout_cnt, 0);
        rst_main = 1'b0;
        tick();
        chk("idle_awready", s_awready, 1);
        chk("idle_arready", s_arready, 1);

        // legal write, B three cycles after the forward completes
        s_awaddr = 12'h010; s_awvalid = 1; s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1;
        m_awready = 1; m_wready = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        chk("w1_awvalid", m_awvalid, 1);
        chk("w1_wvalid", m_wvalid, 1);
        chk("w1_awaddr", m_awaddr, 32'h010);
        chk("w1_wdata", m_wdata, 32'h1234_5678);
        chk("w1_wstrb", m_wstrb, 4'hF);
        tick();
        m_awready = 0; m_wready = 0;
        chk("w1_bready", m_bready, 1);
        chk("w1_awdrop", m_awvalid, 0);
        tick(); tick();
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        chk("w1_bvalid", s_bvalid, 1);
        chk("w1_bresp", s_bresp, 2'b00);
        chk("w1_tcnt", timeout_cnt, 0);
        tick();
        chk("w1_bhold", s_bvalid, 1);
        s_bready = 1;
        tick();
        s_bready = 0;
        chk("w1_bdone", s_bvalid, 0);
        chk("w1_awready", s_awready, 1);

        // W leads AW by two cycles, channels retire separately downstream
        s_wdata = 32'hCAFE_F00D; s_wstrb = 4'h3; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        chk("w2_wready_held", s_wready, 0);
        chk("w2_awready", s_awready, 1);
        chk("w2_no_fwd", m_awvalid, 0);
        tick();
        s_awaddr = 12'h020; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        chk("w2_awvalid", m_awvalid, 1);
        chk("w2_wvalid", m_wvalid, 1);
        chk("w2_awaddr", m_awaddr, 32'h020);
        chk("w2_wdata", m_wdata, 32'hCAFE_F00D);
        m_wready = 1;
        tick();
        m_wready = 0;
        chk("w2_wdrop", m_wvalid, 0);
        chk("w2_awstay", m_awvalid, 1);
        m_awready = 1;
        tick();
        m_awready = 0;
        chk("w2_awdrop", m_awvalid, 0);
        chk("w2_bready", m_bready, 1);
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        chk("w2_bvalid", s_bvalid, 1);
        chk("w2_bresp", s_bresp, 2'b00);
        s_bready = 1;
        tick();
        s_bready = 0;

        // out-of-range read and write, answered locally
        s_araddr = 12'h200; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        chk("r3_no_fwd", m_arvalid, 0);
        chk("r3_rvalid", s_rvalid, 1);
        chk("r3_rresp", s_rresp, 2'b11);
        chk("r3_rdata", s_rdata, 32'hBAD0_0BAD);
        s_rready = 1;
        tick();
        s_rready = 0;
        chk("r3_rdone", s_rvalid, 0);
        s_awaddr = 12'h100; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        chk("w3_no_fwd", m_awvalid, 0);
        chk("w3_bvalid", s_bvalid, 1);
        chk("w3_bresp", s_bresp, 2'b11);
        s_bready = 1;
        tick();
        s_bready = 0;

        // highest legal read address is forwarded
        s_araddr = 12'h0FC; s_arvalid = 1; m_arready = 1;
        tick();
        s_arvalid = 0;
        chk("r4_arvalid", m_arvalid, 1);
        chk("r4_araddr", m_araddr, 32'h0FC);
        tick();
        m_arready = 0;
        chk("r4_rready", m_rready, 1);
        m_rvalid = 1; m_rdata = 32'h0A0B_0C0D; m_rresp = 2'b00;
        tick();
        m_rvalid = 0;
        chk("r4_rvalid", s_rvalid, 1);
        chk("r4_rdata", s_rdata, 32'h0A0B_0C0D);
        chk("r4_rresp", s_rresp, 2'b00);
        s_rready = 1;
        tick();
        s_rready = 0;

        // write with AW never accepted times out eight cycles after forwarding starts
        s_awaddr = 12'h030; s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        chk("w5_awvalid", m_awvalid, 1);
        n = 0;
        for (int i = 0; i < 20 && !s_bvalid; i++) begin
            tick();
            n++;
        end
        chk("w5_latency", n, 8);
        chk("w5_bresp", s_bresp, 2'b10);
        chk("w5_tcnt", timeout_cnt, 1);
        chk("w5_awdrop", m_awvalid, 0);
        chk("w5_late_bready", m_bready, 1);
        s_bready = 1;
        tick();
        s_bready = 0;
        chk("w5_late_idle", m_bready, 1);
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        chk("w5_absorbed", s_bvalid, 0);
        chk("w5_late_clr", m_bready, 0);
        s_awaddr = 12'h040; s_awvalid = 1; s_wvalid = 1; m_awready = 1; m_wready = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        tick();
        m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        chk("w5_next_bvalid", s_bvalid, 1);
        chk("w5_next_bresp", s_bresp, 2'b00);
        chk("w5_next_tcnt", timeout_cnt, 1);
        s_bready = 1;
        tick();
        s_bready = 0;

        // simultaneous read and write timeouts
        rst_main = 1;
        tick();
        rst_main = 0;
        chk("c6_tcnt_rst", timeout_cnt, 0);
        s_awaddr = 12'h050; s_awvalid = 1; s_wvalid = 1; s_araddr = 12'h060; s_arvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        n = 0;
        for (int i = 0; i < 20 && !s_bvalid; i++) begin
            tick();
            n++;
        end
        chk("c6_latency", n, 8);
        chk("c6_rvalid", s_rvalid, 1);
        chk("c6_bresp", s_bresp, 2'b10);
        chk("c6_rresp", s_rresp, 2'b10);
        chk("c6_rdata", s_rdata, 32'hBAD0_0BAD);
        chk("c6_tcnt", timeout_cnt, 2);
        s_bready = 1; s_rready = 1;
        tick();
        s_bready = 0; s_rready = 0;

        // reset while waiting for R, then a clean read
        rst_main = 1;
        tick();
        rst_main = 0;
        s_araddr = 12'h070; s_arvalid = 1; m_arready = 1;
        tick();
        s_arvalid = 0;
        tick();
        m_arready = 0;
        chk("r7_wait_rready", m_rready, 1);
        rst_main = 1; m_rvalid = 1; m_rdata = 32'h1111_2222;
        tick();
        chk("r7_rst_rvalid", s_rvalid, 0);
        chk("r7_rst_rready", m_rready, 0);
        chk("r7_rst_tcnt", timeout_cnt, 0);
        rst_main = 0; m_rvalid = 0;
        tick();
        chk("r7_post_rvalid", s_rvalid, 0);
        chk("r7_post_arready", s_arready, 1);
        s_araddr = 12'h054; s_arvalid = 1; m_arready = 1;
        tick();
        s_arvalid = 0;
        tick();
        m_arready = 0;
        m_rvalid = 1; m_rdata = 32'h55AA_55AA; m_rresp = 2'b00;
        tick();
        m_rvalid = 0;
        chk("r7_rvalid", s_rvalid, 1);
        chk("r7_rdata", s_rdata, 32'h55AA_55AA);
        chk("r7_rresp", s_rresp, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/sda_axil_guard.md
Name: sda_axil_guard

Overview:
- AXI4-Lite guard stage between the shell SDA slave port and the MAC accelerator's AXI-Lite register slave. Sits directly upstream of the accelerator wrapper.
- Forwards legal register accesses unchanged.
- Answers out-of-range addresses locally with DECERR.
- Converts any accelerator access that does not complete within a bounded time into SLVERR, so a hung or reset accelerator can never stall the shell.
- Read and write paths are independent, one outstanding transaction each.

Parameters:
ADDR_W, 12, address width on both sides
ADDR_LIMIT, 12'h100, first illegal byte address; addresses at or above it get DECERR and are not forwarded
TIMEOUT_CYCLES, 1024, cycles allowed from forward start to downstream response (minimum 4)
ERR_DATA, 32'hBAD0_0BAD, RDATA returned on DECERR or read timeout

Ports:
clk_main_a0  in  1  clock
rst_main  in  1  synchronous active-high reset
s_awaddr, s_awvalid  in  ADDR_W, 1  upstream AW
s_awready  out  1  upstream AW ready
s_wdata, s_wstrb, s_wvalid  in  32, 4, 1  upstream W
s_wready  out  1  upstream W ready
s_bresp, s_bvalid  out  2, 1  upstream B
s_bready  in  1  upstream B ready
s_araddr, s_arvalid  in  ADDR_W, 1  upstream AR
s_arready  out  1  upstream AR ready
s_rdata, s_rresp, s_rvalid  out  32, 2, 1  upstream R
s_rready  in  1  upstream R ready
m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid  out  ADDR_W, 1, 32, 4, 1  downstream AW/W
m_awready, m_wready  in  1, 1  downstream AW/W ready
m_bresp, m_bvalid  in  2, 1  downstream B
m_bready  out  1  downstream B ready
m_araddr, m_arvalid  out  ADDR_W, 1  downstream AR
m_arready  in  1  downstream AR ready
m_rdata, m_rresp, m_rvalid  in  32, 2, 1  downstream R
m_rready  out  1  downstream R ready
timeout_cnt  out  16  saturating count of timed-out transactions (read + write)

Behaviour:
Reset
- Synchronous, active-high. Every state register, flag and timer clears in the cycle rst_main is sampled high.
- While rst_main is high, every valid and ready output is 0, timeout_cnt is 0 and data outputs are 0.
- Reset mid-transaction abandons it silently: no response is issued and late flags clear.

Write FSM: WR_IDLE, WR_FWD, WR_WAIT_B, WR_RESP
- WR_IDLE:
  - s_awready=1 until AW is captured; s_wready=1 until W is captured. The two may arrive in any order or in the same cycle.
  - Once both are held: addr>=ADDR_LIMIT goes to WR_RESP with bresp=2'b11; otherwise goes to WR_FWD and clears the timer.
- WR_FWD:
  - m_awvalid and m_wvalid are driven from registered copies. Each drops individually after its own handshake.
  - When both handshakes are done, go to WR_WAIT_B.
- WR_WAIT_B: m_bready=1. On m_bvalid, capture m_bresp and go to WR_RESP.
- WR_RESP: s_bvalid=1 with the held bresp until s_bready, then WR_IDLE.
- Timer:
  - Increments each cycle in WR_FWD and WR_WAIT_B.
  - At TIMEOUT_CYCLES-1 with no completion: drop m_awvalid/m_wvalid, set bresp=2'b10, go to WR_RESP, increment timeout_cnt, set wr_late.
  - If completion and expiry occur in the same cycle, completion wins.
- wr_late: while set, m_bready=1 in every state. The next m_bvalid is absorbed without forwarding and clears wr_late.

Read FSM: RD_IDLE, RD_FWD, RD_WAIT_R, RD_RESP
- Mirrors the write FSM.
- s_arready=1 only in RD_IDLE.
- Out of range: rresp=2'b11 and rdata=ERR_DATA.
- Timeout: rresp=2'b10, rdata=ERR_DATA, and rd_late absorbs the next m_rvalid.

General
- Read and write FSMs run concurrently. Both timeouts in the same cycle add 2 to timeout_cnt, which saturates at 16'hFFFF.
- Latency of a forwarded access is 1 capture cycle, plus the downstream latency, plus 1 response cycle.
- A locally answered DECERR appears 1 cycle after capture.
- Upstream responses hold stable while s_bready/s_rready is low.

Decomposition:
- Package cat_mac_pkg holds:
  - AXI response constants: RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - State enums wr_state_t and rd_state_t.
- One sub-module, axil_guard_timer: counter with clear, enable, and an expire output. Instantiated once per channel.

Test Plan:
- Write 0x010 data 0x1234_5678, downstream B after 3 cycles -> s_bresp=OKAY; m_awaddr=0x010 and m_wdata match; timeout_cnt=0.
- W presented 2 cycles before AW -> both captured, single forward, OKAY.
- Read 0x200 -> no m_arvalid; s_rresp=2'b11, s_rdata=0xBAD0_0BAD one cycle after AR capture.
- Write with m_awready stuck 0, TIMEOUT_CYCLES=8 -> s_bresp=2'b10 at cycle 8; timeout_cnt=1. A late m_bvalid is absorbed, and the next write returns OKAY.
- Concurrent read and write both timing out in the same cycle -> timeout_cnt=2, both SLVERR.
- rst_main asserted while in RD_WAIT_R -> s_rvalid stays 0; after release, a new read completes normally.
